// File: rtl/data_mem_responder.sv
// data_mem_responder
// Multi-channel LSU memory responder. Each channel owns a small FSM that
// latches a request, waits out a fixed latency, then competes for the single
// storage port (lowest index wins, host preload beats every channel). Ready
// pulses last one cycle and the channel re-arms only once both valids drop.
// Optional feature macro: DMEM_PROTOCOL_CHECK_EN enables the sticky
// protocol_error monitor; without it protocol_error is tied low.
module data_mem_responder #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int LATENCY      = 5
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS-1:0]                read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] read_address,
    output logic [NUM_CHANNELS-1:0]                read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data,
    input  logic [NUM_CHANNELS-1:0]                write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] write_data,
    output logic [NUM_CHANNELS-1:0]                write_ready,
    input  logic                                   init_write_enable,
    input  logic [ADDR_BITS-1:0]                   init_address,
    input  logic [DATA_BITS-1:0]                   init_data,
    output logic                                   protocol_error
);

    localparam int DEPTH    = 1 << ADDR_BITS;
    localparam int CH_IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Per-channel request context
    state_e                                 state_q [NUM_CHANNELS];
    state_e                                 state_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][3:0]           cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0]                op_read_q, op_read_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] addr_q, addr_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wdata_q, wdata_d;

    // Registered handshake outputs
    logic [NUM_CHANNELS-1:0]                rd_rdy_q, rd_rdy_d;
    logic [NUM_CHANNELS-1:0]                wr_rdy_q, wr_rdy_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rd_data_q;

    // Storage port arbitration
    logic [NUM_CHANNELS-1:0] req_s;
    logic [NUM_CHANNELS-1:0] grant_s;
    logic                    grant_any_s;
    logic [CH_IDX_W-1:0]     grant_idx_s;
    logic [ADDR_BITS-1:0]    acc_addr_s;
    logic [DATA_BITS-1:0]    acc_wdata_s;
    logic                    mem_we_s;
    logic [DATA_BITS-1:0]    rd_word_s;

    // Contents survive reset, so the array has no reset branch
    logic [DATA_BITS-1:0]    mem_q [DEPTH];

    // A channel competes for storage once its latency counter has expired
    always_comb begin
        req_s = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            req_s[i] = (state_q[i] == ST_GRANT) ||
                       ((state_q[i] == ST_WAIT) && (cnt_q[i] == 4'd0));
        end
    end

    // Fixed-priority arbiter: host preload blocks all grants, else lowest index wins
    always_comb begin
        grant_s     = '0;
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (req_s[i] && !grant_any_s && !init_write_enable) begin
                grant_s[i]  = 1'b1;
                grant_any_s = 1'b1;
                grant_idx_s = CH_IDX_W'(i);
            end else begin
                grant_s[i]  = 1'b0;
            end
        end
    end

    // The single storage access of this cycle belongs to the granted channel
    always_comb begin
        acc_addr_s  = addr_q[grant_idx_s];
        acc_wdata_s = wdata_q[grant_idx_s];
        mem_we_s    = grant_any_s && !op_read_q[grant_idx_s];
        rd_word_s   = mem_q[acc_addr_s];
    end

    // Per-channel FSM next state, context capture and ready generation
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            op_read_d[i] = op_read_q[i];
            addr_d[i]    = addr_q[i];
            wdata_d[i]   = wdata_q[i];
            rd_rdy_d[i]  = 1'b0;
            wr_rdy_d[i]  = 1'b0;
            case (state_q[i])
                ST_IDLE: begin
                    if (read_valid[i]) begin
                        op_read_d[i] = 1'b1;
                        addr_d[i]    = read_address[i];
                        cnt_d[i]     = CNT_LOAD;
                        state_d[i]   = ST_WAIT;
                    end else if (write_valid[i]) begin
                        op_read_d[i] = 1'b0;
                        addr_d[i]    = write_address[i];
                        wdata_d[i]   = write_data[i];
                        cnt_d[i]     = CNT_LOAD;
                        state_d[i]   = ST_WAIT;
                    end else begin
                        state_d[i]   = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q[i] != 4'd0) begin
                        cnt_d[i]    = cnt_q[i] - 4'd1;
                    end else if (grant_s[i]) begin
                        rd_rdy_d[i] = op_read_q[i];
                        wr_rdy_d[i] = !op_read_q[i];
                        state_d[i]  = ST_RELEASE;
                    end else begin
                        state_d[i]  = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (grant_s[i]) begin
                        rd_rdy_d[i] = op_read_q[i];
                        wr_rdy_d[i] = !op_read_q[i];
                        state_d[i]  = ST_RELEASE;
                    end else begin
                        state_d[i]  = ST_GRANT;
                    end
                end
                ST_RELEASE: begin
                    if (!read_valid[i] && !write_valid[i]) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        state_d[i] = ST_RELEASE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Channel state and handshake registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
            end
            cnt_q     <= '0;
            op_read_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_rdy_q  <= '0;
            wr_rdy_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i] <= state_d[i];
            end
            cnt_q     <= cnt_d;
            op_read_q <= op_read_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_rdy_q  <= rd_rdy_d;
            wr_rdy_q  <= wr_rdy_d;
        end
    end

    // Read data captured from the shared port; holds until the next read on that channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (grant_s[i] && op_read_q[i]) begin
                    rd_data_q[i] <= rd_word_s;
                end
            end
        end
    end

    // Storage write: host preload takes the port, otherwise the granted write commits
    always_ff @(posedge clk) begin
        if (init_write_enable) begin
            mem_q[init_address] <= init_data;
        end else if (mem_we_s) begin
            mem_q[acc_addr_s] <= acc_wdata_s;
        end
    end

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic viol_s;
    logic perr_q;

    // A pending channel must keep its valid high and its address/data stable
    always_comb begin
        viol_s = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if ((state_q[i] == ST_WAIT) || (state_q[i] == ST_GRANT)) begin
                if (op_read_q[i]) begin
                    if (!read_valid[i] || (read_address[i] != addr_q[i])) begin
                        viol_s = 1'b1;
                    end else begin
                        viol_s = viol_s;
                    end
                end else begin
                    if (!write_valid[i] || (write_address[i] != addr_q[i]) ||
                        (write_data[i] != wdata_q[i])) begin
                        viol_s = 1'b1;
                    end else begin
                        viol_s = viol_s;
                    end
                end
            end else begin
                viol_s = viol_s;
            end
        end
    end

    // Sticky violation flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_q | viol_s;
        end
    end

    assign protocol_error = perr_q;
`else
    assign protocol_error = 1'b0;
`endif

    assign read_ready  = rd_rdy_q;
    assign write_ready = wr_rdy_q;
    assign read_data   = rd_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (default parameters).
// Table of single transactions plus hand-written multi-cycle sequences;
// expected responses go into a scoreboard queue when a request is driven and
// are matched against ready pulses observed on the falling clock edge.
module tb_data_mem_responder;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      read_valid;
    logic [3:0][7:0] read_address;
    logic [3:0]      read_ready;
    logic [3:0][7:0] read_data;
    logic [3:0]      write_valid;
    logic [3:0][7:0] write_address;
    logic [3:0][7:0] write_data;
    logic [3:0]      write_ready;
    logic            init_write_enable;
    logic [7:0]      init_address;
    logic [7:0]      init_data;
    logic            protocol_error;

`ifdef DMEM_PROTOCOL_CHECK_EN
    localparam int EXP_PERR = 1;
`else
    localparam int EXP_PERR = 0;
`endif

    data_mem_responder dut (
        .clk               (clk),
        .reset             (reset),
        .read_valid        (read_valid),
        .read_address      (read_address),
        .read_ready        (read_ready),
        .read_data         (read_data),
        .write_valid       (write_valid),
        .write_address     (write_address),
        .write_data        (write_data),
        .write_ready       (write_ready),
        .init_write_enable (init_write_enable),
        .init_address      (init_address),
        .init_data         (init_data),
        .protocol_error    (protocol_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         ch;
        bit         wr;
        logic [7:0] data;
        int         due;
    } exp_t;

    typedef struct {
        int         ch;
        bit         wr;
        bit         both;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    exp_t       sbq[$];
    logic [3:0] pend;
    logic [3:0] seen;
    int         hold_left [4];
    int         total  = 0;
    int         passed = 0;
    int         ch1_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            passed++;
        end
    endtask

    // Match ready pulses against the scoreboard, then let requesters release
    task automatic monitor();
        for (int ch = 0; ch < 4; ch++) begin
            if (read_ready[ch] || write_ready[ch]) begin
                int idx;
                idx = -1;
                if (ch == 1 && read_ready[ch]) ch1_pulses++;
                for (int k = 0; k < sbq.size(); k++) begin
                    if (idx < 0 && sbq[k].ch == ch) idx = k;
                end
                if (idx < 0) begin
                    total++;
                    $display("FAIL unexpected_ready ch%0d: actual rd=%0b wr=%0b required none (cycle %0d)",
                             ch, read_ready[ch], write_ready[ch], cyc);
                end else begin
                    check($sformatf("ready_cycle_ch%0d", ch), cyc, sbq[idx].due);
                    check($sformatf("ready_kind_ch%0d", ch), {31'd0, write_ready[ch]}, {31'd0, sbq[idx].wr});
                    if (!sbq[idx].wr) begin
                        check($sformatf("read_data_ch%0d", ch), {24'd0, read_data[ch]}, {24'd0, sbq[idx].data});
                    end
                    sbq.delete(idx);
                    seen[ch] = 1'b1;
                end
            end
        end
        for (int ch = 0; ch < 4; ch++) begin
            if (pend[ch] && seen[ch]) begin
                if (hold_left[ch] == 0) begin
                    read_valid[ch]  = 1'b0;
                    write_valid[ch] = 1'b0;
                    pend[ch]        = 1'b0;
                    seen[ch]        = 1'b0;
                end else begin
                    hold_left[ch]--;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic issue(input int ch, input bit wr, input bit both, input logic [7:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp, input int extra, input int hold);
        exp_t e;
        if (!wr) begin
            read_valid[ch]   = 1'b1;
            read_address[ch] = addr;
            if (both) begin
                write_valid[ch]   = 1'b1;
                write_address[ch] = addr;
                write_data[ch]    = wd;
            end
        end else begin
            write_valid[ch]   = 1'b1;
            write_address[ch] = addr;
            write_data[ch]    = wd;
        end
        e.ch   = ch;
        e.wr   = wr;
        e.data = exp;
        e.due  = cyc + 1 + 5 + extra;
        sbq.push_back(e);
        pend[ch]      = 1'b1;
        seen[ch]      = 1'b0;
        hold_left[ch] = hold;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((pend != 4'd0 || sbq.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        if (pend != 4'd0 || sbq.size() != 0) begin
            total++;
            $display("FAIL timeout: actual pending=%b queued=%0d required idle", pend, sbq.size());
            sbq.delete();
            pend        = 4'd0;
            read_valid  = 4'd0;
            write_valid = 4'd0;
        end
        tick();
        tick();
    endtask

    task automatic preload(input logic [7:0] addr, input logic [7:0] data);
        init_write_enable = 1'b1;
        init_address      = addr;
        init_data         = data;
        tick();
        init_write_enable = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_ready"}, {28'd0, read_ready}, 32'd0);
        check({tag, "_write_ready"}, {28'd0, write_ready}, 32'd0);
        check({tag, "_read_data"}, read_data, 32'd0);
        check({tag, "_protocol_error"}, {31'd0, protocol_error}, 32'd0);
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{0, 1'b0, 1'b0, 8'd3,   8'h00, 8'h2A};
        vecs[1]  = '{2, 1'b1, 1'b0, 8'd20,  8'd26, 8'h00};
        vecs[2]  = '{2, 1'b0, 1'b0, 8'd20,  8'h00, 8'd26};
        vecs[3]  = '{1, 1'b0, 1'b0, 8'd255, 8'h00, 8'h81};
        vecs[4]  = '{3, 1'b0, 1'b0, 8'd0,   8'h00, 8'h11};
        vecs[5]  = '{3, 1'b1, 1'b0, 8'd255, 8'h7E, 8'h00};
        vecs[6]  = '{0, 1'b0, 1'b0, 8'd255, 8'h00, 8'h7E};
        vecs[7]  = '{1, 1'b1, 1'b0, 8'd0,   8'hF0, 8'h00};
        vecs[8]  = '{2, 1'b0, 1'b0, 8'd0,   8'h00, 8'hF0};
        vecs[9]  = '{0, 1'b0, 1'b0, 8'd100, 8'h00, 8'hC3};
        vecs[10] = '{1, 1'b0, 1'b1, 8'd100, 8'h00, 8'hC3};
        vecs[11] = '{2, 1'b0, 1'b0, 8'd100, 8'h00, 8'hC3};

        reset             = 1'b0;
        read_valid        = '0;
        read_address      = '0;
        write_valid       = '0;
        write_address     = '0;
        write_data        = '0;
        init_write_enable = 1'b0;
        init_address      = '0;
        init_data         = '0;
        pend              = '0;
        seen              = '0;
        for (int i = 0; i < 4; i++) hold_left[i] = 0;

        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        preload(8'd3,   8'h2A);
        preload(8'd255, 8'h81);
        preload(8'd0,   8'h11);
        preload(8'd100, 8'hC3);
        preload(8'd9,   8'h33);
        for (int i = 0; i < 4; i++) preload(8'(60 + i), 8'(8'hA0 + i));
        tick();

        // Single transactions, one at a time
        for (int v = 0; v < 12; v++) begin
            issue(vecs[v].ch, vecs[v].wr, vecs[v].both, vecs[v].addr, vecs[v].wdata, vecs[v].exp, 0, 0);
            wait_idle();
        end
        check("read_data_hold_ch0", {24'd0, read_data[0]}, 32'h0000_00C3);

        // Four simultaneous reads serialise in index order
        for (int i = 0; i < 4; i++) issue(i, 1'b0, 1'b0, 8'(60 + i), 8'h00, 8'(8'hA0 + i), i, 0);
        wait_idle();

        // Write on ch0 then read on ch1 of the same address, same edge
        issue(0, 1'b1, 1'b0, 8'd50, 8'h99, 8'h00, 0, 0);
        issue(1, 1'b0, 1'b0, 8'd50, 8'h00, 8'h99, 1, 0);
        wait_idle();

        // Host preload on the grant edge delays the channel by one cycle
        issue(0, 1'b0, 1'b0, 8'd100, 8'h00, 8'hC3, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        init_write_enable = 1'b1;
        init_address      = 8'd200;
        init_data         = 8'h5A;
        tick();
        init_write_enable = 1'b0;
        wait_idle();
        issue(2, 1'b0, 1'b0, 8'd200, 8'h00, 8'h5A, 0, 0);
        wait_idle();

        // Valid held two extra cycles after ready: single pulse only
        ch1_pulses = 0;
        issue(1, 1'b0, 1'b0, 8'd20, 8'h00, 8'd26, 0, 2);
        wait_idle();
        for (int i = 0; i < 4; i++) tick();
        check("ch1_single_pulse", ch1_pulses, 32'd1);

        // Reset in the middle of a pending write aborts it
        write_valid[0]   = 1'b1;
        write_address[0] = 8'd9;
        write_data[0]    = 8'h55;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        write_valid[0] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        issue(0, 1'b0, 1'b0, 8'd9, 8'h00, 8'h33, 0, 0);
        wait_idle();

        // ch3 drops read_valid while waiting
        check("perr_before", {31'd0, protocol_error}, 32'd0);
        issue(3, 1'b0, 1'b0, 8'd3, 8'h00, 8'h2A, 0, 0);
        tick();
        tick();
        read_valid[3] = 1'b0;
        wait_idle();
        check("perr_after_drop", {31'd0, protocol_error}, EXP_PERR);
        tick();
        check("perr_sticky", {31'd0, protocol_error}, EXP_PERR);
        reset = 1'b0;
        #1;
        check("perr_cleared_by_reset", {31'd0, protocol_error}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
